// File: rtl/fetch_control_unit.sv
// Fetch-stage redirect/flush/stall controller for JMP, BEQ and LDR load-use hazards.
// Optional taken-branch counter enabled by defining BRANCH_STATS_EN.
module fetch_control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] instruction_decode,
  input  logic [15:0] pc_decode,
  input  logic [19:0] instruction_fetch,
  input  logic        zero_flag,
  output logic [1:0]  select_pc_mux,
  output logic [15:0] branch_address,
  output logic [1:0]  flush,
  output logic [1:0]  select_nop_mux
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0] branch_count
`endif
);

  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_LDR = 4'hC;

  typedef enum logic [1:0] {RUN, REDIRECT, FLUSH, STALL} state_t;

  state_t      state;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic        taken;
  logic        load_use;
  logic [15:0] target;
  logic        unused_fetch_bits;

  // PC-relative target; the 12-bit offset is signed and the sum wraps at 2^16.
  function automatic logic [15:0] beq_target(input logic [15:0] pc, input logic [11:0] ofs);
    logic signed [15:0] ofs_sx;
    ofs_sx = {{4{ofs[11]}}, ofs};
    return pc + ofs_sx;
  endfunction

  assign opcode   = instruction_decode[19:16];
  assign rd       = instruction_decode[15:12];
  assign taken    = (opcode == OP_JMP) || ((opcode == OP_BEQ) && zero_flag);
  assign target   = (opcode == OP_JMP) ? instruction_decode[15:0]
                                       : beq_target(pc_decode, instruction_decode[11:0]);
  assign load_use = (opcode == OP_LDR) &&
                    ((instruction_fetch[11:8] == rd) || (instruction_fetch[7:4] == rd));
  assign unused_fetch_bits = ^{instruction_fetch[19:12], instruction_fetch[3:0]};

  // Outputs are loaded with the values belonging to the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= RUN;
      select_pc_mux  <= 2'b00;
      branch_address <= 16'h0000;
      flush          <= 2'b00;
      select_nop_mux <= 2'b00;
`ifdef BRANCH_STATS_EN
      branch_count   <= 16'h0000;
`endif
    end else begin
      case (state)
        RUN: begin
          if (taken) begin
            state          <= REDIRECT;
            select_pc_mux  <= 2'b01;
            branch_address <= target;
            flush          <= 2'b01;
            select_nop_mux <= 2'b00;
`ifdef BRANCH_STATS_EN
            if (branch_count != 16'hFFFF) branch_count <= branch_count + 16'd1;
`endif
          end else if (load_use) begin
            state          <= STALL;
            select_pc_mux  <= 2'b00;
            flush          <= 2'b00;
            select_nop_mux <= 2'b01;
          end else begin
            state          <= RUN;
            select_pc_mux  <= 2'b00;
            flush          <= 2'b00;
            select_nop_mux <= 2'b00;
          end
        end
        REDIRECT: begin
          state          <= FLUSH;
          select_pc_mux  <= 2'b00;
          flush          <= 2'b01;
          select_nop_mux <= 2'b00;
        end
        default: begin
          state          <= RUN;
          select_pc_mux  <= 2'b00;
          flush          <= 2'b00;
          select_nop_mux <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_control_unit.sv
// Bench for fetch_control_unit: directed scenarios then random traffic against a schedule-queue model.
module tb_fetch_control_unit;

  logic        clk;
  logic        reset;
  logic [19:0] instruction_decode;
  logic [15:0] pc_decode;
  logic [19:0] instruction_fetch;
  logic        zero_flag;
  logic [1:0]  select_pc_mux;
  logic [15:0] branch_address;
  logic [1:0]  flush;
  logic [1:0]  select_nop_mux;
`ifdef BRANCH_STATS_EN
  logic [15:0] branch_count;
`endif

  fetch_control_unit dut (
    .clk                (clk),
    .reset              (reset),
    .instruction_decode (instruction_decode),
    .pc_decode          (pc_decode),
    .instruction_fetch  (instruction_fetch),
    .zero_flag          (zero_flag),
    .select_pc_mux      (select_pc_mux),
    .branch_address     (branch_address),
    .flush              (flush),
    .select_nop_mux     (select_nop_mux)
`ifdef BRANCH_STATS_EN
    ,
    .branch_count       (branch_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pc;
    logic [15:0] ba;
    logic [1:0]  fl;
    logic [1:0]  nop;
  } exp_t;

  exp_t   sched[$];
  int     total = 0;
  int     bad   = 0;
  int     last_tgt = 0;
  int     model_cnt = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  // Model: while the controller is free, the decode instruction schedules the
  // next one, two or three cycles of outputs; busy cycles ignore the inputs.
  task automatic plan();
    int   op, rd, ofs, v;
    exp_t e;
    op = int'(instruction_decode[19:16]);
    rd = int'(instruction_decode[15:12]);
    if (op == 10 || (op == 11 && zero_flag)) begin
      if (op == 10) v = int'(instruction_decode[15:0]);
      else begin
        ofs = int'(instruction_decode[11:0]);
        if (ofs >= 2048) ofs = ofs - 4096;
        v = int'(pc_decode) + ofs;
        if (v < 0) v = v + 65536;
        if (v >= 65536) v = v - 65536;
      end
      last_tgt = v;
      if (model_cnt < 65535) model_cnt++;
      e = '{2'b01, 16'(v), 2'b01, 2'b00}; sched.push_back(e);
      e = '{2'b00, 16'(v), 2'b01, 2'b00}; sched.push_back(e);
      e = '{2'b00, 16'(v), 2'b00, 2'b00}; sched.push_back(e);
    end else if (op == 12 && (int'(instruction_fetch[11:8]) == rd || int'(instruction_fetch[7:4]) == rd)) begin
      e = '{2'b00, 16'(last_tgt), 2'b00, 2'b01}; sched.push_back(e);
      e = '{2'b00, 16'(last_tgt), 2'b00, 2'b00}; sched.push_back(e);
    end else begin
      e = '{2'b00, 16'(last_tgt), 2'b00, 2'b00}; sched.push_back(e);
    end
  endtask

  task automatic step();
    exp_t e;
    if (sched.size() == 0) plan();
    @(posedge clk);
    #1;
    e = sched.pop_front();
    chk("sel_pc", {14'b0, select_pc_mux}, {14'b0, e.pc});
    chk("br_addr", branch_address, e.ba);
    chk("flush", {14'b0, flush}, {14'b0, e.fl});
    chk("sel_nop", {14'b0, select_nop_mux}, {14'b0, e.nop});
`ifdef BRANCH_STATS_EN
    chk("br_count", branch_count, 16'(model_cnt));
`endif
  endtask

  task automatic drive(input logic [19:0] d, input logic [15:0] pc, input logic [19:0] f, input logic z);
    instruction_decode = d;
    pc_decode          = pc;
    instruction_fetch  = f;
    zero_flag          = z;
  endtask

  // Reset pulse placed between clock edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, "_pc"}, {14'b0, select_pc_mux}, 16'h0000);
    chk({tag, "_ba"}, branch_address, 16'h0000);
    chk({tag, "_fl"}, {14'b0, flush}, 16'h0000);
    chk({tag, "_nop"}, {14'b0, select_nop_mux}, 16'h0000);
`ifdef BRANCH_STATS_EN
    chk({tag, "_cnt"}, branch_count, 16'h0000);
`endif
    sched.delete();
    last_tgt  = 0;
    model_cnt = 0;
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] r2;
    logic [3:0]  op;

    reset = 1'b0;
    drive(20'h00000, 16'h0000, 20'h00000, 1'b0);
    #1 reset = 1'b1;
    #1;
    chk("rst_pc", {14'b0, select_pc_mux}, 16'h0000);
    chk("rst_ba", branch_address, 16'h0000);
    chk("rst_fl", {14'b0, flush}, 16'h0000);
    chk("rst_nop", {14'b0, select_nop_mux}, 16'h0000);
    #2 reset = 1'b0;

    step();

    // JMP: redirect next cycle, one flush cycle, then back to run.
    drive(20'hA0040, 16'h0000, 20'h00000, 1'b0);
    step();
    chk("jmp_pc", {14'b0, select_pc_mux}, 16'h0001);
    chk("jmp_ba", branch_address, 16'h0040);
    chk("jmp_fl", {14'b0, flush}, 16'h0001);
    drive(20'h00000, 16'h0000, 20'h00000, 1'b0);
    step();
    chk("jmp_flush_fl", {14'b0, flush}, 16'h0001);
    chk("jmp_flush_pc", {14'b0, select_pc_mux}, 16'h0000);
    step();
    chk("jmp_run_fl", {14'b0, flush}, 16'h0000);

    // BEQ backwards offset, taken and not taken.
    drive(20'hB0FFE, 16'h0010, 20'h00000, 1'b1);
    step();
    chk("beq_ba", branch_address, 16'h000E);
    chk("beq_pc", {14'b0, select_pc_mux}, 16'h0001);
    drive(20'h00000, 16'h0000, 20'h00000, 1'b0);
    step();
    step();
    drive(20'hB0FFE, 16'h0010, 20'h00000, 1'b0);
    step();
    chk("beq_nt_pc", {14'b0, select_pc_mux}, 16'h0000);
    chk("beq_nt_fl", {14'b0, flush}, 16'h0000);

    // Load-use stall, then a non-dependent fetch.
    drive(20'hC3000, 16'h0020, 20'h10300, 1'b0);
    step();
    chk("ldr_nop", {14'b0, select_nop_mux}, 16'h0001);
    drive(20'h00000, 16'h0000, 20'h00000, 1'b0);
    step();
    chk("ldr_nop_end", {14'b0, select_nop_mux}, 16'h0000);
    drive(20'hC3000, 16'h0020, 20'h10450, 1'b0);
    step();
    chk("ldr_nostall", {14'b0, select_nop_mux}, 16'h0000);

    // BEQ target wraps; JMP held in decode through REDIRECT/FLUSH is ignored.
    drive(20'hB0002, 16'hFFFF, 20'h00000, 1'b1);
    step();
    chk("wrap_ba", branch_address, 16'h0001);
    drive(20'hA1234, 16'h0000, 20'h00000, 1'b0);
    step();
    step();
    chk("ign_pc", {14'b0, select_pc_mux}, 16'h0000);
    chk("ign_ba", branch_address, 16'h0001);
    drive(20'h00000, 16'h0000, 20'h00000, 1'b0);
    step();

    // Reset in the middle of a redirect, then decode evaluated at once.
    drive(20'hA0077, 16'h0000, 20'h00000, 1'b0);
    step();
    async_reset("rst_redir");
    drive(20'hA0050, 16'h0000, 20'h00000, 1'b0);
    step();
    chk("post_rst_pc", {14'b0, select_pc_mux}, 16'h0001);
    chk("post_rst_ba", branch_address, 16'h0050);
    drive(20'h00000, 16'h0000, 20'h00000, 1'b0);
    step();
    step();

`ifdef BRANCH_STATS_EN
    async_reset("rst_cnt");
    for (int i = 0; i < 3; i++) begin
      drive(20'hA0100 + 20'(i), 16'h0000, 20'h00000, 1'b0);
      step();
      drive(20'h00000, 16'h0000, 20'h00000, 1'b0);
      step();
      step();
    end
    chk("cnt3", branch_count, 16'h0003);
    force dut.branch_count = 16'hFFFE;
    #1 release dut.branch_count;
    model_cnt = 65534;
    for (int i = 0; i < 2; i++) begin
      drive(20'hA0200, 16'h0000, 20'h00000, 1'b0);
      step();
      drive(20'h00000, 16'h0000, 20'h00000, 1'b0);
      step();
      step();
    end
    chk("cnt_sat", branch_count, 16'hFFFF);
`endif

    // Random traffic with a narrow register range so hazards occur often.
    for (int n = 0; n < 600; n++) begin
      r  = $urandom;
      r2 = $urandom;
      case (r[18:16])
        3'd0, 3'd1: op = 4'hA;
        3'd2, 3'd3: op = 4'hB;
        3'd4, 3'd5: op = 4'hC;
        default:    op = r[23:20];
      endcase
      drive({op, 2'b00, r[13:0]}, r2[31:16],
            {r2[7:0], 2'b00, r2[9:8], 2'b00, r2[11:10], r2[15:12]}, r[24]);
      if (r[31:26] == 6'd0) async_reset("rnd_rst");
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_control_unit.md
FETCH_CONTROL_UNIT -- requirements
Module: fetch_control_unit

Interface
REQ-001 SHALL have ports:
  clk  in  1  pipeline clock, rising edge.
  reset  in  1  asynchronous, active-high.
  instruction_decode  in  20  instruction held in the fetch/decode register.
  pc_decode  in  16  PC of instruction_decode.
  instruction_fetch  in  20  instruction currently leaving the ROM.
  zero_flag  in  1  condition for BEQ, valid with instruction_decode.
  select_pc_mux  out  2  00 = sequential PC, 01 = branch_address; 10/11 never driven.
  branch_address  out  16  redirect target.
  flush  out  2  01 = clear fetch/decode register; 00 = none.
  select_nop_mux  out  2  01 = hold PC and fetch/decode register (bubble); 00 = run.
  branch_count  out  16  taken redirects; present only with BRANCH_STATS_EN.
REQ-002 SHALL use a single clock domain (clk); reset is asynchronous and active-high.

Function
REQ-003 SHALL decode opcode = instruction[19:16]: 4'hA JMP, 4'hB BEQ, 4'hC LDR; all others are non-control.
REQ-004 SHALL compute the JMP target as instruction_decode[15:0].
REQ-005 SHALL compute the BEQ target as pc_decode + sign-extended instruction_decode[11:0], modulo 2^16 (wraps, no overflow flag).
REQ-006 SHALL treat BEQ as taken only when zero_flag = 1; JMP is always taken.
REQ-007 SHALL detect load-use when decode is LDR with rd = instruction_decode[15:12] and instruction_fetch[11:8] == rd or instruction_fetch[7:4] == rd.
REQ-008 SHALL implement an FSM with states RUN, REDIRECT, FLUSH, STALL; all outputs are registered (driven from state/registers only).
REQ-009 RUN: outputs select_pc_mux=00, flush=00, select_nop_mux=00; taken branch -> REDIRECT (latch target); else load-use -> STALL; else stay.
REQ-010 REDIRECT (1 cycle): select_pc_mux=01, branch_address=latched target, flush=01; -> FLUSH.
REQ-011 FLUSH (1 cycle): select_pc_mux=00, flush=01, decode inputs ignored; -> RUN.
REQ-012 STALL (1 cycle): select_nop_mux=01, flush=00, select_pc_mux=00; -> RUN.
REQ-013 Taken-branch detection to select_pc_mux=01 SHALL be exactly 1 clock; wrong-path penalty exactly 2 cycles.
REQ-014 Simultaneous taken branch and load-use in RUN SHALL go to REDIRECT only (branch priority).
REQ-015 Control instructions arriving in REDIRECT, FLUSH, STALL SHALL be ignored (no nested redirect).
REQ-016 branch_address SHALL retain its last latched value outside REDIRECT.

Reset
REQ-017 Reset asserted SHALL immediately force state RUN, select_pc_mux=00, branch_address=16'h0000, flush=00, select_nop_mux=00, branch_count=0.
REQ-018 Reset mid-REDIRECT/FLUSH/STALL SHALL abandon the sequence; first post-reset cycle evaluates decode in RUN.

Configuration
REQ-019 With BRANCH_STATS_EN defined, branch_count SHALL increment by 1 on each entry to REDIRECT, saturating at 16'hFFFF.
REQ-020 Without BRANCH_STATS_EN, branch_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-021 Decode 20'hA0040 in RUN -> next cycle select_pc_mux=01, branch_address=16'h0040, flush=01; next flush=01, select_pc_mux=00; then RUN.
REQ-022 BEQ 20'hB0FFE, pc_decode=16'h0010, zero_flag=1 -> branch_address=16'h000E; same with zero_flag=0 -> outputs stay 00.
REQ-023 Decode LDR 20'hC3000, fetch 20'h10300 -> one cycle select_nop_mux=01, then 00; fetch 20'h10450 -> no stall.
REQ-024 BEQ pc_decode=16'hFFFF, offset 12'h002, zero_flag=1 -> branch_address=16'h0001 (wrap); JMP decode during FLUSH ignored.
REQ-025 Reset asserted during REDIRECT -> all outputs 0 asynchronously; BRANCH_STATS_EN: 3 JMPs -> branch_count=3, preset near 16'hFFFF saturates.
